multicycle_ctrl_fsm: RTL

Multicycle sequencer for the 16-bit MIPS core. It steps one instruction through fetch, decode, execute, memory and write-back over several clocks on a shared ALU and a shared unified memory port. It decodes the same 3-bit opcode set as the single-cycle control unit and drives the same datapath select encodings. It also waits on a memory ready handshake and flags a bus timeout.

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 22 ++
 rtl/multicycle_ctrl_fsm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, datapath-select and state encodings shared by the multicycle control unit
package ctrl_pkg;
    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_SLT   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_INC  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR,
        MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, ERROR
    } state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and raises timeout on the last allowed one
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Held at zero outside memory states, so every entry starts a fresh count
    always_comb begin
        cnt_d   = (in_wait && !mem_ready) ? cnt_q + CNT_W'(1) : '0;
        timeout = (TIMEOUT_CYC != 0) && in_wait && !mem_ready && (cnt_q == LIMIT);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: fetch/decode/execute/memory/write-back sequencer with memory wait and bus timeout
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] ALU_op,
    output logic [1:0] reg_DST,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       bus_err,
    output logic [3:0] state_o
);
    state_t state_q, state_d;
    logic   in_wait, timeout, unused_zero;
    // zero qualifies pc_write_cond in the datapath, not in the sequencer
    assign unused_zero = zero;
    assign in_wait     = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign state_o     = state_q;

    mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .in_wait  (in_wait),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_ALU;
        ALU_src_A     = 1'b0;
        ALU_src_B     = SRCB_B;
        ALU_op        = ALU_FUNCT;
        reg_DST       = DST_RT;
        mem_to_reg    = M2R_ALU;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        bus_err       = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                ALU_src_B = SRCB_INC;
                ALU_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : (timeout ? ERROR : FETCH);
            end
            DECODE: begin
                ALU_src_B = SRCB_BOFF;
                ALU_op    = ALU_ADD;
                state_d   = (opcode == OP_R) ? EXEC_R :
                            (opcode == OP_SLTI || opcode == OP_ADDI) ? EXEC_I :
                            (opcode == OP_LW || opcode == OP_SW) ? ADDR :
                            (opcode == OP_J || opcode == OP_JAL) ? JUMP : BRANCH;
            end
            EXEC_R: begin
                ALU_src_A = 1'b1;
                state_d   = WB_R;
            end
            WB_R: begin
                reg_DST    = DST_RD;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXEC_I: begin
                ALU_src_A = 1'b1;
                ALU_src_B = SRCB_IMM;
                ALU_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDR: begin
                ALU_src_A = 1'b1;
                ALU_src_B = SRCB_IMM;
                ALU_op    = ALU_ADD;
                state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? WB_MEM : (timeout ? ERROR : MEM_RD);
            end
            WB_MEM: begin
                mem_to_reg = M2R_MDR;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : (timeout ? ERROR : MEM_WR);
            end
            BRANCH: begin
                ALU_src_A     = 1'b1;
                ALU_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_JUMP;
                instr_done = 1'b1;
                reg_DST    = (opcode == OP_JAL) ? DST_RA : DST_RT;
                mem_to_reg = (opcode == OP_JAL) ? M2R_PC : M2R_ALU;
                reg_write  = (opcode == OP_JAL);
                state_d    = FETCH;
            end
            ERROR: bus_err = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
endmodule
